// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the PS/2 set-2 keyboard to ASCII transmit path.
`timescale 1ns/1ps
package ps2_kbd_pkg;

    // Decoder position within a make/break/extended byte sequence.
    typedef enum logic [1:0] {
        StIdle,
        StBrk,
        StExt,
        StExtBrk
    } ps2_state_e;

    // Set-2 scancodes that steer the decoder or have special translations.
    localparam logic [7:0] ScBreak  = 8'hF0;
    localparam logic [7:0] ScExt    = 8'hE0;
    localparam logic [7:0] ScLShift = 8'h12;
    localparam logic [7:0] ScRShift = 8'h59;
    localparam logic [7:0] ScCaps   = 8'h58;
    localparam logic [7:0] ScEnter  = 8'h5A;
    localparam logic [7:0] ScSpace  = 8'h29;
    localparam logic [7:0] ScBksp   = 8'h66;

    // ASCII control characters produced by the translator.
    localparam logic [7:0] AsciiCr = 8'h0D;
    localparam logic [7:0] AsciiLf = 8'h0A;
    localparam logic [7:0] AsciiBs = 8'h08;
    localparam logic [7:0] AsciiSp = 8'h20;

    function automatic logic is_shift_code(input logic [7:0] code);
        return (code == ScLShift) || (code == ScRShift);
    endfunction

endpackage

// File: rtl/ps2_scancode_to_ascii.sv
// Combinational translation of a set-2 make code to ASCII using Shift and Caps Lock state.
`timescale 1ns/1ps
module ps2_scancode_to_ascii
    import ps2_kbd_pkg::*;
(
    input  logic [7:0] code_i,
    input  logic       shift_i,
    input  logic       caps_i,
    output logic [7:0] ascii_o,
    output logic       valid_o
);

    logic [7:0] lower;
    logic [7:0] plain;
    logic [7:0] shifted;
    logic       is_letter;
    logic       is_other;

    // Look up the key class, then apply case folding: letters follow shift^caps, the rest shift.
    always_comb begin
        lower     = 8'h00;
        plain     = 8'h00;
        shifted   = 8'h00;
        is_letter = 1'b0;
        is_other  = 1'b0;
        case (code_i)
            8'h1C: begin is_letter = 1'b1; lower = 8'h61; end
            8'h32: begin is_letter = 1'b1; lower = 8'h62; end
            8'h21: begin is_letter = 1'b1; lower = 8'h63; end
            8'h23: begin is_letter = 1'b1; lower = 8'h64; end
            8'h24: begin is_letter = 1'b1; lower = 8'h65; end
            8'h2B: begin is_letter = 1'b1; lower = 8'h66; end
            8'h34: begin is_letter = 1'b1; lower = 8'h67; end
            8'h33: begin is_letter = 1'b1; lower = 8'h68; end
            8'h43: begin is_letter = 1'b1; lower = 8'h69; end
            8'h3B: begin is_letter = 1'b1; lower = 8'h6A; end
            8'h42: begin is_letter = 1'b1; lower = 8'h6B; end
            8'h4B: begin is_letter = 1'b1; lower = 8'h6C; end
            8'h3A: begin is_letter = 1'b1; lower = 8'h6D; end
            8'h31: begin is_letter = 1'b1; lower = 8'h6E; end
            8'h44: begin is_letter = 1'b1; lower = 8'h6F; end
            8'h4D: begin is_letter = 1'b1; lower = 8'h70; end
            8'h15: begin is_letter = 1'b1; lower = 8'h71; end
            8'h2D: begin is_letter = 1'b1; lower = 8'h72; end
            8'h1B: begin is_letter = 1'b1; lower = 8'h73; end
            8'h2C: begin is_letter = 1'b1; lower = 8'h74; end
            8'h3C: begin is_letter = 1'b1; lower = 8'h75; end
            8'h2A: begin is_letter = 1'b1; lower = 8'h76; end
            8'h1D: begin is_letter = 1'b1; lower = 8'h77; end
            8'h22: begin is_letter = 1'b1; lower = 8'h78; end
            8'h35: begin is_letter = 1'b1; lower = 8'h79; end
            8'h1A: begin is_letter = 1'b1; lower = 8'h7A; end
            8'h45: begin is_other = 1'b1; plain = 8'h30; shifted = 8'h29; end
            8'h16: begin is_other = 1'b1; plain = 8'h31; shifted = 8'h21; end
            8'h1E: begin is_other = 1'b1; plain = 8'h32; shifted = 8'h40; end
            8'h26: begin is_other = 1'b1; plain = 8'h33; shifted = 8'h23; end
            8'h25: begin is_other = 1'b1; plain = 8'h34; shifted = 8'h24; end
            8'h2E: begin is_other = 1'b1; plain = 8'h35; shifted = 8'h25; end
            8'h36: begin is_other = 1'b1; plain = 8'h36; shifted = 8'h5E; end
            8'h3D: begin is_other = 1'b1; plain = 8'h37; shifted = 8'h26; end
            8'h3E: begin is_other = 1'b1; plain = 8'h38; shifted = 8'h2A; end
            8'h46: begin is_other = 1'b1; plain = 8'h39; shifted = 8'h28; end
            ScSpace: begin is_other = 1'b1; plain = AsciiSp; shifted = AsciiSp; end
            ScEnter: begin is_other = 1'b1; plain = AsciiCr; shifted = AsciiCr; end
            ScBksp:  begin is_other = 1'b1; plain = AsciiBs; shifted = AsciiBs; end
            default: ;
        endcase
        valid_o = is_letter | is_other;
        if (is_letter) begin
            ascii_o = (shift_i ^ caps_i) ? (lower - 8'h20) : lower;
        end else begin
            ascii_o = shift_i ? shifted : plain;
        end
    end

endmodule

// File: rtl/ps2_ascii_tx_queue.sv
// PS/2 set-2 decoder with Shift/Caps tracking, ASCII FIFO and paced UART drain.
// Optional macro ECHO_CRLF_EN: Enter enqueues CR followed by LF via a one-entry pending register.
`timescale 1ns/1ps
module ps2_ascii_tx_queue
    import ps2_kbd_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned TX_GAP = 104170
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [7:0]               scancode,
    input  logic                     new_code,
    input  logic                     tx_ready,
    output logic                     en_send,
    output logic [7:0]               send_data,
    output logic [7:0]               last_ascii,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CW   = AW + 1;
    localparam int unsigned GapW = (TX_GAP > 1) ? $clog2(TX_GAP) : 1;

    // Reset synchroniser: assertion is immediate, release follows two clock edges.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    // Shift in ones after reset_n releases.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    // Decoder state and translation.
    ps2_state_e state_q;
    logic       shift_q;
    logic       caps_q;
    logic       push_q;
    logic [7:0] push_data_q;
    logic [7:0] tr_ascii;
    logic       tr_valid;
    logic       make_strobe;
    logic       push_new;

    ps2_scancode_to_ascii u_xlate (
        .code_i  (scancode),
        .shift_i (shift_q),
        .caps_i  (caps_q),
        .ascii_o (tr_ascii),
        .valid_o (tr_valid)
    );

    assign make_strobe = new_code && (state_q == StIdle) &&
                         (scancode != ScBreak) && (scancode != ScExt);
    assign push_new    = make_strobe && tr_valid;

`ifdef ECHO_CRLF_EN
    logic       pend_q;
    logic [7:0] pend_data_q;
    logic       pend_lf_q;
    logic       is_enter;
    assign is_enter = (scancode == ScEnter);
`endif

    // Decoder FSM: sequence tracking, modifier state and the registered push towards the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            shift_q     <= 1'b0;
            caps_q      <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= 8'h00;
`ifdef ECHO_CRLF_EN
            pend_q      <= 1'b0;
            pend_data_q <= 8'h00;
            pend_lf_q   <= 1'b0;
`endif
        end else begin
            if (new_code) begin
                unique case (state_q)
                    StIdle: begin
                        if (scancode == ScBreak) begin
                            state_q <= StBrk;
                        end else if (scancode == ScExt) begin
                            state_q <= StExt;
                        end else begin
                            if (is_shift_code(scancode)) shift_q <= 1'b1;
                            if (scancode == ScCaps)      caps_q  <= ~caps_q;
                        end
                    end
                    StBrk: begin
                        if (is_shift_code(scancode)) shift_q <= 1'b0;
                        state_q <= StIdle;
                    end
                    StExt:    state_q <= (scancode == ScBreak) ? StExtBrk : StIdle;
                    StExtBrk: state_q <= StIdle;
                endcase
            end
`ifdef ECHO_CRLF_EN
            // A pending byte always goes first; a make landing in the same cycle is parked
            // behind it. PS/2 strobes are ~1 ms apart, so the pending slot never overfills.
            if (pend_q) begin
                push_q      <= 1'b1;
                push_data_q <= pend_data_q;
                if (push_new) begin
                    pend_data_q <= tr_ascii;
                    pend_lf_q   <= is_enter;
                end else if (pend_lf_q) begin
                    pend_data_q <= AsciiLf;
                    pend_lf_q   <= 1'b0;
                end else begin
                    pend_q <= 1'b0;
                end
            end else begin
                push_q <= push_new;
                if (push_new) push_data_q <= tr_ascii;
                pend_q      <= push_new && is_enter;
                pend_data_q <= AsciiLf;
                pend_lf_q   <= 1'b0;
            end
`else
            push_q <= push_new;
            if (push_new) push_data_q <= tr_ascii;
`endif
        end
    end

    // FIFO and drain.
    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_q;
    logic [AW-1:0]   rd_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic [GapW-1:0] gap_q;
    logic            en_send_q;
    logic [7:0]      send_data_q;
    logic [7:0]      last_ascii_q;
    logic            overflow_q;
    logic            full;
    logic            empty;
    logic            pop;
    logic            push_acc;
    logic [7:0]      head;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    // An empty queue forwards the incoming push straight to the UART in the same cycle.
    assign pop      = tx_ready && (gap_q == '0) && (!empty || push_q);
    assign push_acc = push_q && (!full || pop);
    assign head     = empty ? push_data_q : mem_q[rd_q];

    // Occupancy next state.
    always_comb begin
        count_d = count_q;
        case ({push_acc, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage array; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_acc) mem_q[wr_q] <= push_data_q;
    end

    // Pointers, occupancy, pacing and registered UART outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q         <= '0;
            rd_q         <= '0;
            count_q      <= '0;
            gap_q        <= '0;
            en_send_q    <= 1'b0;
            send_data_q  <= 8'h00;
            last_ascii_q <= 8'h00;
            overflow_q   <= 1'b0;
        end else begin
            count_q   <= count_d;
            en_send_q <= pop;
            if (push_acc) begin
                wr_q         <= wr_q + 1'b1;
                last_ascii_q <= push_data_q;
            end
            if (push_q && !push_acc) overflow_q <= 1'b1;
            if (pop) begin
                rd_q        <= rd_q + 1'b1;
                send_data_q <= head;
                gap_q       <= GapW'(TX_GAP - 1);
            end else if (gap_q != '0) begin
                gap_q <= gap_q - 1'b1;
            end
        end
    end

    assign en_send    = en_send_q;
    assign send_data  = send_data_q;
    assign last_ascii = last_ascii_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: doc/ps2_ascii_tx_queue.md
Name: ps2_ascii_tx_queue

Overview:
- Sits between ps2_keyboard (scancode/new_code) and the uart transmit input (en_send/send_data).
- Decodes PS/2 set-2 make/break/extended sequences and tracks Shift and Caps Lock.
- Translates printable keys to ASCII and buffers them in a FIFO.
- Drains the FIFO to the UART one byte at a time, paced by a ready input and a minimum inter-byte gap, so typed text streams out RsTx.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- TX_GAP, 104170, minimum clk cycles between en_send pulses (one 10-bit frame at 9600 baud, 100 MHz).

Ports:
- clk  in  1  system clock, 100 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- scancode  in  8  byte from ps2_keyboard.
- new_code  in  1  one-cycle strobe; scancode valid in that cycle.
- tx_ready  in  1  uart can accept a byte; tie to 1 if the uart has no busy output.
- en_send  out  1  one-cycle strobe to uart.
- send_data  out  8  ASCII byte; valid when en_send=1 and held until the next send.
- last_ascii  out  8  most recently enqueued byte, for the seven-segment display.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky; set when a byte is dropped because the FIFO is full.

Behaviour:
- Reset (async assert, sync release): decoder state IDLE, shift=0, caps=0, FIFO empty, gap counter 0. All outputs are 0.
- Decoder FSM advances only on new_code:
  - IDLE: F0 -> BRK; E0 -> EXT; any other byte is a make.
  - BRK: byte is a release, then -> IDLE.
  - EXT: F0 -> EXT_BRK; any other byte -> IDLE, ignored.
  - EXT_BRK: any byte -> IDLE, ignored.
- Make of 12 or 59 sets shift. Release of 12 or 59 clears shift. Other releases are ignored.
- Make of 58 toggles caps; repeated makes keep toggling.
- Translation (combinational, from the make code, shift and caps):
  - Letters a-z (1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A): uppercase when shift XOR caps.
  - Digits 0-9 (45,16,1E,26,25,2E,36,3D,3E,46): shifted gives ")!@#$%^&*(".
  - 29 -> 20; 5A -> 0D; 66 -> 08.
  - Anything else -> invalid, nothing is enqueued.
- Push happens the cycle after a valid make strobe. last_ascii updates on every accepted push.
- Typematic repeat makes enqueue each time.
- FIFO push rules:
  - Not full: accepted.
  - Full with a pop in the same cycle: accepted.
  - Full without a pop: dropped, and overflow is set.
- Drain: when the FIFO is non-empty, tx_ready=1 and gap=0:
  - Pop the head, load send_data, pulse en_send for exactly one cycle, load gap=TX_GAP-1.
  - gap decrements to 0 every cycle.
  - Latency from push into an empty, idle queue to en_send is 1 cycle.
- fifo_count wraps never; pointers wrap modulo DEPTH.
- A new_code arriving while a second CRLF byte is pending is still decoded; its push follows the pending push.

Optional Feature:
- Macro ECHO_CRLF_EN.
- Defined: Enter (5A) enqueues 0D then 0A in consecutive cycles. The second push is held in a one-entry pending register. If the FIFO is full it drops with overflow set.
- Undefined: Enter enqueues 0D only, and there is no pending register.

Decomposition:
- Package ps2_kbd_pkg holds:
  - the decoder state typedef (IDLE, BRK, EXT, EXT_BRK);
  - scancode constants (F0, E0, LSHIFT 12, RSHIFT 59, CAPS 58, ENTER 5A, SPACE 29, BKSP 66);
  - ASCII constants (CR, LF, BS).
- Sub-module ps2_scancode_to_ascii: combinational (code, shift, caps) -> (ascii, valid).
- The FIFO stays inline.

Test Plan:
- Sequence 1C, F0 1C -> one en_send with send_data=61; fifo_count returns to 0; last_ascii=61.
- Sequence 12, 16, F0 16, F0 12, 16 -> bytes 21 then 31 sent, at least TX_GAP cycles apart.
- Sequence 58, F0 58, 1C, 12, 1C -> 41 then 61 (caps XOR shift).
- Sequence E0 75, E0 F0 75, F0 1C -> nothing sent; FSM back in IDLE; the following 1C sends 61.
- With tx_ready=0, push DEPTH+2 letters -> fifo_count=DEPTH, overflow=1. Then raise tx_ready -> exactly DEPTH bytes sent, in order.
- 5A with ECHO_CRLF_EN -> 0D then 0A; without it -> 0D only. Asserting reset_n=0 mid-drain -> en_send=0 immediately and fifo_count=0.
